disp_share_arbiter: RTL

- Shares the board's single 4-digit seven-segment driver between two requesters, e.g. a counter readout and a status/message source.
- Round-robin arbitration with a minimum time slice per grant.
- Drives the driver's 16-bit hex word and 4-bit active-low decimal-point inputs from registered outputs.
- Sits between the application logic and the multiplexed display driver, on the 50 MHz system clock.

---
 rtl/disp_share_arbiter_pkg.sv | 23 ++
 rtl/disp_share_arbiter_slice_timer.sv | 29 ++
 rtl/disp_share_arbiter.sv | 115 +++++++++++
 3 files changed

// File: rtl/disp_share_arbiter_pkg.sv
// Shared types and constants for the two-requester seven-segment display arbiter.
package disp_share_arbiter_pkg;

    localparam int unsigned NUM_W         = 16;
    localparam int unsigned DP_W          = 4;
    localparam int unsigned SLICE_DEFAULT = 50_000_000;

    localparam logic [NUM_W-1:0] NUM_IDLE = 16'h0000;
    localparam logic [DP_W-1:0]  DP_OFF   = 4'b1111;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SERVE0 = 2'd1,
        S_SERVE1 = 2'd2
    } state_t;

    // Payload presented to the multiplexed display driver
    typedef struct packed {
        logic [NUM_W-1:0] num;
        logic [DP_W-1:0]  dp;
    } disp_word_t;

endpackage

// File: rtl/disp_share_arbiter_slice_timer.sv
// Saturating grant time-slice counter; expired flags the last cycle of a slice.
module disp_share_arbiter_slice_timer #(
    parameter int unsigned SLICE = 50_000_000,
    parameter int unsigned CW    = 26
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic inc,
    output logic expired_c
);

    localparam logic [CW-1:0] LAST = CW'(SLICE - 1);

    logic [CW-1:0] count;

    always_ff @(posedge clk) begin
        if (!reset) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc && (count != LAST)) begin
            count <= count + CW'(1);
        end
    end

    assign expired_c = (count == LAST);

endmodule

// File: rtl/disp_share_arbiter.sv
// Round-robin owner selection for the single 4-digit display, with a minimum slice per grant.
module disp_share_arbiter
    import disp_share_arbiter_pkg::*;
#(
    parameter int unsigned SLICE = SLICE_DEFAULT,
    parameter int unsigned CW    = 26
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req0,
    input  logic [NUM_W-1:0] num0,
    input  logic [DP_W-1:0]  dp0,
    input  logic             req1,
    input  logic [NUM_W-1:0] num1,
    input  logic [DP_W-1:0]  dp1,
    output logic             gnt0,
    output logic             gnt1,
    output logic [NUM_W-1:0] disp_num,
    output logic [DP_W-1:0]  dp_out
);

    state_t     state;
    state_t     state_next;
    logic       last_served;
    logic       expired_c;
    logic       timer_clr_c;
    logic       timer_inc_c;
    disp_word_t disp_next;

    disp_share_arbiter_slice_timer #(
        .SLICE (SLICE),
        .CW    (CW)
    ) u_slice_timer (
        .clk       (clk),
        .reset     (reset),
        .clr       (timer_clr_c),
        .inc       (timer_inc_c),
        .expired_c (expired_c)
    );

    // State, pointer and registered driver outputs
    always_ff @(posedge clk) begin
        if (!reset) begin
            state       <= S_IDLE;
            last_served <= 1'b1;
            gnt0        <= 1'b0;
            gnt1        <= 1'b0;
            disp_num    <= NUM_IDLE;
            dp_out      <= DP_OFF;
        end else begin
            state    <= state_next;
            gnt0     <= (state_next == S_SERVE0);
            gnt1     <= (state_next == S_SERVE1);
            disp_num <= disp_next.num;
            dp_out   <= disp_next.dp;
            if (state_next == S_SERVE0) begin
                last_served <= 1'b0;
            end else if (state_next == S_SERVE1) begin
                last_served <= 1'b1;
            end
        end
    end

    // Next owner: release beats preemption; a tie goes to whoever was not served last
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: begin
                if (req0 && req1) begin
                    state_next = last_served ? S_SERVE0 : S_SERVE1;
                end else if (req0) begin
                    state_next = S_SERVE0;
                end else if (req1) begin
                    state_next = S_SERVE1;
                end
            end
            S_SERVE0: begin
                if (!req0) begin
                    state_next = req1 ? S_SERVE1 : S_IDLE;
                end else if (expired_c && req1) begin
                    state_next = S_SERVE1;
                end
            end
            S_SERVE1: begin
                if (!req1) begin
                    state_next = req0 ? S_SERVE0 : S_IDLE;
                end else if (expired_c && req0) begin
                    state_next = S_SERVE0;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    // Data follows the incoming owner so it lands together with its grant
    always_comb begin
        disp_next.num = NUM_IDLE;
        disp_next.dp  = DP_OFF;
        case (state_next)
            S_SERVE0: begin
                disp_next.num = num0;
                disp_next.dp  = dp0;
            end
            S_SERVE1: begin
                disp_next.num = num1;
                disp_next.dp  = dp1;
            end
            default: ;
        endcase
    end

    assign timer_clr_c = (state_next != state) || (state == S_IDLE);
    assign timer_inc_c = !timer_clr_c;

endmodule
